// File: rtl/neural_pkg.sv
// ---------------------------------------------------------------------------
// neural_pkg
// Shared definitions for the neuron operand loader:
//   - WIDTH         : data word / operand width
//   - state_e       : loader FSM states
//   - FULL_LEN      : words in a full frame (coeffA, coeffB, bias, inputA, inputB)
//   - INPUT_LEN     : words in an input-only frame (inputA, inputB)
//   - IDX_*         : word index of each operand within a full frame
//   - slot_e        : operand slot a word is routed to
//   - word_slot()   : maps (frame kind, word index) to an operand slot
//   - final_idx()   : index of the last word for a frame kind
// ---------------------------------------------------------------------------
package neural_pkg;

    localparam int WIDTH      = 16;
    localparam int FULL_LEN   = 5;
    localparam int INPUT_LEN  = 2;

    localparam int IDX_COEFFA = 0;
    localparam int IDX_COEFFB = 1;
    localparam int IDX_BIAS   = 2;
    localparam int IDX_INPUTA = 3;
    localparam int IDX_INPUTB = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        SLOT_COEFFA = 3'd0,
        SLOT_COEFFB = 3'd1,
        SLOT_BIAS   = 3'd2,
        SLOT_INPUTA = 3'd3,
        SLOT_INPUTB = 3'd4
    } slot_e;

    // Route a word to its operand slot. Input-only frames carry inputA then inputB.
    function automatic slot_e word_slot(input logic full, input logic [2:0] idx);
        slot_e slot;
        if (full) begin
            case (idx)
                3'(IDX_COEFFA): slot = SLOT_COEFFA;
                3'(IDX_COEFFB): slot = SLOT_COEFFB;
                3'(IDX_BIAS):   slot = SLOT_BIAS;
                3'(IDX_INPUTA): slot = SLOT_INPUTA;
                default:        slot = SLOT_INPUTB;
            endcase
        end else begin
            if (idx == 3'd0) begin
                slot = SLOT_INPUTA;
            end else begin
                slot = SLOT_INPUTB;
            end
        end
        return slot;
    endfunction

    // Index of the word that must carry in_last for the given frame kind.
    function automatic logic [2:0] final_idx(input logic full);
        logic [2:0] idx;
        if (full) begin
            idx = 3'(FULL_LEN - 1);
        end else begin
            idx = 3'(INPUT_LEN - 1);
        end
        return idx;
    endfunction

endpackage

// File: rtl/neuron_operand_loader.sv
// ---------------------------------------------------------------------------
// neuron_operand_loader
// Assembles a serial stream of operand words into one operand set and
// commits it atomically to registered outputs feeding the two-input neuron.
//
// Ports
//   clk, rst_n        : clock, synchronous active-low reset
//   in_data/in_valid/in_ready/in_last/in_full : serial word stream
//                       (in_full sampled on the first word of a frame)
//   inputA, inputB, coeffA, coeffB, bias : committed operand set
//   op_valid/op_ready : committed set is pending / consumer has taken it
//   coeff_loaded      : a full frame has been committed since reset
//   frame_err         : one-cycle pulse when a frame is dropped
// ---------------------------------------------------------------------------
module neuron_operand_loader
    import neural_pkg::*;
#(
    parameter int width = WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic             in_full,
    output logic [width-1:0] inputA,
    output logic [width-1:0] inputB,
    output logic [width-1:0] coeffA,
    output logic [width-1:0] coeffB,
    output logic [width-1:0] bias,
    output logic             op_valid,
    input  logic             op_ready,
    output logic             coeff_loaded,
    output logic             frame_err
);

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic       full_q, full_d;

    // Shadow bank. inputB is always the final word of a frame, so it is taken
    // straight from in_data at commit and needs no shadow copy.
    logic [width-1:0] sh_coeffa_q;
    logic [width-1:0] sh_coeffb_q;
    logic [width-1:0] sh_bias_q;
    logic [width-1:0] sh_inputa_q;

    logic [width-1:0] inputa_q, inputb_q, coeffa_q, coeffb_q, bias_q;
    logic             op_valid_q;
    logic             coeff_loaded_q;
    logic             frame_err_q;

    logic             in_ready_s;
    logic             accept_s;
    logic             frame_full_s;
    logic             final_s;
    logic             shadow_we_s;
    logic             commit_s;
    logic             err_s;

    // Ready is withheld while a set is pending and forced low during reset.
    assign in_ready_s   = rst_n && (state_q != ST_HOLD);
    assign accept_s     = in_valid && in_ready_s;
    // The first word carries the frame kind; later words use the latched copy.
    assign frame_full_s = (state_q == ST_IDLE) ? in_full : full_q;
    assign final_s      = (idx_q == final_idx(frame_full_s));

    // Next-state, index and commit/error decode for the frame FSM.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        full_d      = full_q;
        shadow_we_s = 1'b0;
        commit_s    = 1'b0;
        err_s       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    full_d      = in_full;
                    shadow_we_s = 1'b1;
                    if (in_last) begin
                        // No frame is a single word long.
                        err_s   = 1'b1;
                        idx_d   = 3'd0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = 3'd1;
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (accept_s) begin
                    shadow_we_s = 1'b1;
                    if (final_s) begin
                        idx_d = 3'd0;
                        if (!in_last) begin
                            err_s   = 1'b1;
                            state_d = ST_DRAIN;
                        end else if (full_q || coeff_loaded_q) begin
                            commit_s = 1'b1;
                            state_d  = ST_HOLD;
                        end else begin
                            // Input-only frame with no coefficients to pair with.
                            err_s   = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else if (in_last) begin
                        err_s   = 1'b1;
                        idx_d   = 3'd0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_DRAIN: begin
                if (accept_s && in_last) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_HOLD: begin
                if (op_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 3'd0;
            end
        endcase
    end

    // FSM state, word index and latched frame kind.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            full_q  <= full_d;
        end
    end

    // Shadow bank capture of accepted words.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_coeffa_q <= '0;
            sh_coeffb_q <= '0;
            sh_bias_q   <= '0;
            sh_inputa_q <= '0;
        end else if (shadow_we_s) begin
            case (word_slot(frame_full_s, idx_q))
                SLOT_COEFFA: sh_coeffa_q <= in_data;
                SLOT_COEFFB: sh_coeffb_q <= in_data;
                SLOT_BIAS:   sh_bias_q   <= in_data;
                SLOT_INPUTA: sh_inputa_q <= in_data;
                default:     ;
            endcase
        end else begin
            sh_coeffa_q <= sh_coeffa_q;
        end
    end

    // Committed operand set, handshake and status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inputa_q       <= '0;
            inputb_q       <= '0;
            coeffa_q       <= '0;
            coeffb_q       <= '0;
            bias_q         <= '0;
            op_valid_q     <= 1'b0;
            coeff_loaded_q <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            frame_err_q <= err_s;
            if (commit_s) begin
                inputa_q   <= sh_inputa_q;
                inputb_q   <= in_data;
                op_valid_q <= 1'b1;
                if (full_q) begin
                    coeffa_q       <= sh_coeffa_q;
                    coeffb_q       <= sh_coeffb_q;
                    bias_q         <= sh_bias_q;
                    coeff_loaded_q <= 1'b1;
                end else begin
                    coeff_loaded_q <= coeff_loaded_q;
                end
            end else if ((state_q == ST_HOLD) && op_ready) begin
                op_valid_q <= 1'b0;
            end else begin
                op_valid_q <= op_valid_q;
            end
        end
    end

    assign in_ready     = in_ready_s;
    assign inputA       = inputa_q;
    assign inputB       = inputb_q;
    assign coeffA       = coeffa_q;
    assign coeffB       = coeffb_q;
    assign bias         = bias_q;
    assign op_valid     = op_valid_q;
    assign coeff_loaded = coeff_loaded_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_neuron_operand_loader.sv
module tb_neuron_operand_loader;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic        in_full;
    logic [15:0] inputA, inputB, coeffA, coeffB, bias;
    logic        op_valid;
    logic        op_ready;
    logic        coeff_loaded;
    logic        frame_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        is_err;
        logic [15:0] ia;
        logic [15:0] ib;
        logic [15:0] ca;
        logic [15:0] cb;
        logic [15:0] bs;
    } exp_t;

    exp_t sb[$];

    neuron_operand_loader #(.width(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_last      (in_last),
        .in_full      (in_full),
        .inputA       (inputA),
        .inputB       (inputB),
        .coeffA       (coeffA),
        .coeffB       (coeffB),
        .bias         (bias),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .coeff_loaded (coeff_loaded),
        .frame_err    (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1;
        e.ia = 16'h0; e.ib = 16'h0; e.ca = 16'h0; e.cb = 16'h0; e.bs = 16'h0;
        sb.push_back(e);
    endtask

    task automatic push_commit(input logic [15:0] ia, input logic [15:0] ib,
                               input logic [15:0] ca, input logic [15:0] cb,
                               input logic [15:0] bs);
        exp_t e;
        e.is_err = 1'b0;
        e.ia = ia; e.ib = ib; e.ca = ca; e.cb = cb; e.bs = bs;
        sb.push_back(e);
    endtask

    // Present one word and wait (bounded) until it is accepted; returns 1ns after the accepting edge.
    task automatic send(input logic [15:0] d, input logic last, input logic full);
        bit done;
        done     = 1'b0;
        in_data  = d;
        in_last  = last;
        in_full  = full;
        in_valid = 1'b1;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: word %h never accepted", d);
        end
    endtask

    // Scoreboard monitor: pops an expectation on each frame_err pulse and each op_valid rise.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (frame_err) begin
                    if (sb.size() == 0) begin
                        chk("sb_unexpected_err", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_kind_err", 32'(frame_err), 32'(e.is_err));
                    end
                end
                if (op_valid && !prev) begin
                    if (sb.size() == 0) begin
                        chk("sb_unexpected_commit", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_kind_commit", 32'(e.is_err), 32'd0);
                        chk("sb_inputA", 32'(inputA), 32'(e.ia));
                        chk("sb_inputB", 32'(inputB), 32'(e.ib));
                        chk("sb_coeffA", 32'(coeffA), 32'(e.ca));
                        chk("sb_coeffB", 32'(coeffB), 32'(e.cb));
                        chk("sb_bias",   32'(bias),   32'(e.bs));
                        chk("sb_coeff_loaded", 32'(coeff_loaded), 32'd1);
                    end
                end
            end
            prev = op_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        in_data  = 16'h0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_full  = 1'b0;
        op_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_op_valid", 32'(op_valid), 32'd0);
        chk("rst_coeff_loaded", 32'(coeff_loaded), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_operands", {inputA, inputB}, 32'd0);
        chk("rst_coeffs", {coeffA, coeffB}, 32'd0);
        chk("rst_bias", 32'(bias), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Input-only frame before any coefficients are loaded
        push_err();
        send(16'h1111, 1'b0, 1'b0);
        send(16'h2222, 1'b1, 1'b0);
        chk("nocoef_err_pulse", 32'(frame_err), 32'd1);
        chk("nocoef_op_valid", 32'(op_valid), 32'd0);
        chk("nocoef_inputs", {inputA, inputB}, 32'd0);

        // Full frame
        push_commit(16'h0200, 16'h0300, 16'h0100, 16'h0080, 16'hFF00);
        send(16'h0100, 1'b0, 1'b1);
        send(16'h0080, 1'b0, 1'b1);
        send(16'hFF00, 1'b0, 1'b1);
        send(16'h0200, 1'b0, 1'b1);
        chk("full_no_early_commit", 32'(op_valid), 32'd0);
        send(16'h0300, 1'b1, 1'b1);
        chk("full_commit_lat", 32'(op_valid), 32'd1);

        // Input-only frame reuses coefficients
        push_commit(16'h0010, 16'h0020, 16'h0100, 16'h0080, 16'hFF00);
        send(16'h0010, 1'b0, 1'b0);
        send(16'h0020, 1'b1, 1'b0);
        chk("inonly_commit_lat", 32'(op_valid), 32'd1);

        // Full frame with in_last on word 3
        push_err();
        send(16'hAAAA, 1'b0, 1'b1);
        send(16'hBBBB, 1'b0, 1'b1);
        send(16'hCCCC, 1'b1, 1'b1);
        chk("early_last_err", 32'(frame_err), 32'd1);
        chk("early_last_op_valid", 32'(op_valid), 32'd0);
        chk("early_last_inputs", {inputA, inputB}, 32'h0010_0020);
        chk("early_last_coeffs", {coeffA, coeffB}, 32'h0100_0080);
        chk("early_last_bias", 32'(bias), 32'h0000_FF00);

        // Subsequent valid frame commits
        push_commit(16'h0004, 16'h0005, 16'h0001, 16'h0002, 16'h0003);
        send(16'h0001, 1'b0, 1'b1);
        send(16'h0002, 1'b0, 1'b1);
        send(16'h0003, 1'b0, 1'b1);
        send(16'h0004, 1'b0, 1'b1);
        send(16'h0005, 1'b1, 1'b1);
        chk("recover_commit_lat", 32'(op_valid), 32'd1);

        // Full frame missing in_last on word 5, then two words swallowed by DRAIN
        push_err();
        send(16'h000A, 1'b0, 1'b1);
        send(16'h000B, 1'b0, 1'b1);
        send(16'h000C, 1'b0, 1'b1);
        send(16'h000D, 1'b0, 1'b1);
        send(16'h000E, 1'b0, 1'b1);
        chk("missing_last_err", 32'(frame_err), 32'd1);
        send(16'h0077, 1'b0, 1'b0);
        chk("drain_no_err", 32'(frame_err), 32'd0);
        send(16'h0088, 1'b1, 1'b0);
        chk("drain_end_no_err", 32'(frame_err), 32'd0);
        chk("drain_op_valid", 32'(op_valid), 32'd0);
        chk("drain_inputs_kept", {inputA, inputB}, 32'h0004_0005);
        push_commit(16'h0011, 16'h0022, 16'h0001, 16'h0002, 16'h0003);
        send(16'h0011, 1'b0, 1'b0);
        send(16'h0022, 1'b1, 1'b0);
        chk("after_drain_commit", 32'(op_valid), 32'd1);

        // in_last on the very first word
        push_err();
        send(16'h0999, 1'b1, 1'b1);
        chk("single_word_err", 32'(frame_err), 32'd1);

        // HOLD with op_ready low while upstream keeps offering a word
        op_ready = 1'b0;
        push_commit(16'h4000, 16'h5000, 16'h1000, 16'h2000, 16'h3000);
        send(16'h1000, 1'b0, 1'b1);
        send(16'h2000, 1'b0, 1'b1);
        send(16'h3000, 1'b0, 1'b1);
        send(16'h4000, 1'b0, 1'b1);
        send(16'h5000, 1'b1, 1'b1);
        in_data  = 16'hDEAD;
        in_valid = 1'b1;
        in_full  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_op_valid", 32'(op_valid), 32'd1);
            chk("hold_operands", {inputA, inputB}, 32'h4000_5000);
            chk("hold_coeffs", {coeffA, coeffB}, 32'h1000_2000);
        end
        op_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("release_op_valid", 32'(op_valid), 32'd0);
        chk("release_in_ready", 32'(in_ready), 32'd1);
        chk("release_operands", {inputA, inputB}, 32'h4000_5000);

        // Reset in the middle of a frame
        send(16'h5555, 1'b0, 1'b1);
        send(16'h6666, 1'b0, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_frame_err", 32'(frame_err), 32'd0);
        chk("midrst_op_valid", 32'(op_valid), 32'd0);
        chk("midrst_coeff_loaded", 32'(coeff_loaded), 32'd0);
        chk("midrst_operands", {inputA, inputB}, 32'd0);
        chk("midrst_coeffs", {coeffA, coeffB}, 32'd0);
        chk("midrst_bias", 32'(bias), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("postrst_frame_err", 32'(frame_err), 32'd0);

        // Coefficients were cleared by reset, so an input-only frame is dropped again
        push_err();
        send(16'h0101, 1'b0, 1'b0);
        send(16'h0202, 1'b1, 1'b0);
        chk("postrst_nocoef_err", 32'(frame_err), 32'd1);
        chk("postrst_inputs", {inputA, inputB}, 32'd0);

        repeat (4) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/neuron_operand_loader.md
# neuron_operand_loader

Upstream staging stage for the two-input neuron: accepts a serial stream of 16-bit fixed-point words over a valid/ready handshake and assembles them into one operand set (inputA, inputB, coeffA, coeffB, bias). The set is committed atomically to registered outputs that drive the neuron's operand ports directly, so the neuron never sees a partially updated set. It supports full frames (coefficients, bias and inputs) and input-only frames that reuse the last committed coefficients. It flags malformed frames and holds each committed set until the consumer takes it.

## Interface
- `width`, 16: bit width of every data word and operand; must equal the neuron's `width`.
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_data` in `width`: serial operand word.
- `in_valid` in 1: `in_data`/`in_last`/`in_full` are valid.
- `in_ready` out 1: loader can accept a word.
- `in_last` in 1: final word of the frame.
- `in_full` in 1: frame kind, sampled on the first word only; 1 = full frame, 0 = input-only frame.
- `inputA`, `inputB`, `coeffA`, `coeffB`, `bias` out `width` each: committed operand set, to the neuron.
- `op_valid` out 1: committed set is new and not yet taken.
- `op_ready` in 1: consumer has sampled the neuron result for the current set.
- `coeff_loaded` out 1: at least one full frame has been committed since reset.
- `frame_err` out 1: one-cycle pulse when a frame is dropped.

## Operation
- A word transfers on a cycle where `in_valid && in_ready`.
- Full frame word order: coeffA, coeffB, bias, inputA, inputB (5 words). Input-only frame word order: inputA, inputB (2 words).
- Words go into shadow registers. The output registers change only on commit.
- Commit condition: the final word of the frame (index 4 full, index 1 input-only) arrives with `in_last=1`.
  - Input-only commit copies shadow inputA/B only; coeffA/coeffB/bias keep their values.
  - Full commit sets `coeff_loaded=1`.
- FSM states: IDLE, LOAD, DRAIN, HOLD.
  - IDLE: `in_ready=1`; word index is 0.
    - First word accepted → LOAD, and `in_full` is latched.
    - If that first word also ends the frame (`in_last=1` on the first word) → error, back to IDLE.
  - LOAD: `in_ready=1`; the index increments on each transfer.
    - `in_last=1` before the final index → error → IDLE.
    - Final index with `in_last=1` → commit → HOLD.
    - Final index with `in_last=0` → error → DRAIN.
  - DRAIN: `in_ready=1`; words are discarded until one with `in_last=1` is accepted → IDLE.
  - HOLD: `in_ready=0`, `op_valid=1`. On `op_ready=1` → IDLE.
- An input-only frame while `coeff_loaded=0` is an error. It is handled like any other frame (LOAD/DRAIN), but the words are discarded and there is no commit.
- On error the shadow contents are discarded, output registers are unchanged, and `op_valid` stays 0.
- No arithmetic is performed. Word contents pass through bit-exact; the fixed-point format is owned by the neuron's multiplier.

## Timing
- Reset (`rst_n=0` at a clock edge):
  - state IDLE, index 0;
  - all operand outputs 0, `op_valid=0`, `coeff_loaded=0`, `frame_err=0`;
  - `in_ready` is forced to 0 while `rst_n=0`.
- Reset mid-frame or in HOLD aborts immediately, with no commit and no `frame_err`.
- Commit latency: final word accepted at edge N, then at edge N+1 the operands are updated and `op_valid=1`. Operands are stable from that point until the next commit.
- HOLD exit: `op_ready=1` sampled at edge M makes `op_valid=0` and `in_ready=1` after M. There is no accept in the same cycle as the release.
- `frame_err` is asserted for exactly the one cycle after the offending word is accepted.
- Minimum frame period: 5 words + 1 HOLD cycle (full frame); 2 + 1 (input-only), with `op_ready` tied high.
- `op_ready` is ignored outside HOLD.

## Structure
- Shared package `neural_pkg`:
  - `WIDTH` = 16;
  - FSM state enum;
  - frame lengths `FULL_LEN`=5, `INPUT_LEN`=2;
  - word index constants `IDX_COEFFA`..`IDX_INPUTB`.
- Single module, no sub-module. The shadow register bank and the index counter stay inline.

## Test plan
- Reset, then full frame 0x0100, 0x0080, 0xFF00, 0x0200, 0x0300 → one cycle after the last word, coeffA=0x0100, coeffB=0x0080, bias=0xFF00, inputA=0x0200, inputB=0x0300, `op_valid=1`, `coeff_loaded=1`.
- Then input-only frame 0x0010, 0x0020 → inputA=0x0010, inputB=0x0020; coeffs/bias unchanged.
- Input-only frame right after reset → `frame_err` pulse, outputs stay 0, `op_valid=0`.
- Full frame with `in_last` on word 3 → `frame_err`, previous outputs unchanged. A subsequent valid frame commits normally.
- Full frame missing `in_last` on word 5, followed by 2 extra words (the second with `in_last=1`) → `frame_err`, extra words swallowed by DRAIN, back to IDLE.
- In HOLD, hold `op_ready=0` for 10 cycles while `in_valid=1` → `in_ready=0`, outputs stable. Then `op_ready=1` → `op_valid=0` and `in_ready=1` next cycle. Separately, assert `rst_n=0` mid-frame → all outputs 0 with no `frame_err`.
